op_rr_scheduler: RTL

- Round-robin scheduler sharing one two-operand datapath (operands a, b) among NREQ requesters.
- Each requester presents an (a, b) pair with valid/ready. The block grants one requester, issues the pair to the datapath, waits for the datapath result, and returns it to the granted requester.
- Sits between the per-requester stimulus/sequence sources and the single compute datapath. Only one transaction is outstanding at a time.

---
 rtl/op_rr_scheduler_if.sv | 36 +++
 rtl/op_rr_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/op_rr_scheduler_if.sv
// Handshake bundle between requesters, the op_rr_scheduler and the shared datapath.
// The master modport belongs to the environment (requesters plus datapath). The slave modport belongs to the scheduler.
interface op_rr_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int RES_W  = 64
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [RES_W-1:0]       rsp_data;
    logic                   rsp_err;
    logic                   dp_valid;
    logic [DATA_W-1:0]      dp_a;
    logic [DATA_W-1:0]      dp_b;
    logic                   dp_ready;
    logic                   dp_rsp_valid;
    logic [RES_W-1:0]       dp_rsp_data;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, dp_ready, dp_rsp_valid, dp_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, dp_valid, dp_a, dp_b, grant_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, dp_ready, dp_rsp_valid, dp_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, dp_valid, dp_a, dp_b, grant_id, busy
    );
endinterface

// File: rtl/op_rr_scheduler.sv
// Round-robin scheduler that shares one two-operand datapath among NREQ requesters, with one transaction in flight.
// Optional response timeout is enabled by defining OP_RR_SCHEDULER_TIMEOUT_EN.
module op_rr_scheduler #(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 32,
    parameter int RES_W       = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input logic         clk,
    input logic         resetn,
    op_rr_scheduler_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [RES_W-1:0]  data_q, data_d;
    logic              dpv_q, dpv_d;
    logic [NREQ-1:0]   rspv_q, rspv_d;
    logic              busy_q, busy_d;
    logic [ID_W:0]     pick;
    logic              sel_any;
    logic [ID_W-1:0]   sel_id;
    logic              timeout_hit;

    // The result is {found, index}. The first set bit after 'last' wins, with wrap-around.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] v, input logic [ID_W-1:0] last);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (v[idx]) r = {1'b1, ID_W'(idx)};
        end
        return r;
    endfunction

    assign pick    = rr_pick(bus.req_valid, last_q);
    assign sel_any = pick[ID_W];
    assign sel_id  = pick[ID_W-1:0];

    // Gating with resetn keeps an accept strobe from appearing in a cycle whose edge is a reset.
    assign bus.req_ready = (state_q == IDLE && resetn && sel_any) ? (NREQ'(1) << sel_id) : '0;

`ifdef OP_RR_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q != WAIT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (bus.dp_rsp_valid) err_d = 1'b0;
            else if (timeout_hit) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    a_d     = bus.req_a[int'(sel_id)*DATA_W +: DATA_W];
                    b_d     = bus.req_b[int'(sel_id)*DATA_W +: DATA_W];
                    grant_d = sel_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (bus.dp_ready) state_d = WAIT;
            WAIT: begin
                // A real result takes priority over a timeout that expires in the same cycle.
                if (bus.dp_rsp_valid) begin
                    data_d  = bus.dp_rsp_data;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    data_d  = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dpv_d  = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
        rspv_d = (state_d == RESP) ? (NREQ'(1) << grant_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            dpv_q   <= 1'b0;
            rspv_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            dpv_q   <= dpv_d;
            rspv_q  <= rspv_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.dp_valid  = dpv_q;
    assign bus.dp_a      = a_q;
    assign bus.dp_b      = b_q;
    assign bus.rsp_valid = rspv_q;
    assign bus.rsp_data  = data_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
endmodule
